// File: rtl/tlc_pkg.sv
// Shared light codes and FSM state constants for the junction scheduler.
package tlc_pkg;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    localparam logic [2:0] S_AR_NS = 3'd0;
    localparam logic [2:0] S_NS_G  = 3'd1;
    localparam logic [2:0] S_NS_Y  = 3'd2;
    localparam logic [2:0] S_AR_X  = 3'd3;
    localparam logic [2:0] S_PED   = 3'd4;
    localparam logic [2:0] S_EW_G  = 3'd5;
    localparam logic [2:0] S_EW_Y  = 3'd6;

endpackage

// File: rtl/tlc_dwell_timer.sv
// Dwell up-counter: clears on request, optionally holds once the limit is reached,
// and flags when the count equals the runtime limit.
module tlc_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             sat_en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i) begin
            cnt_d = '0;
        end else if (sat_en_i && done_o) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tlc_junction_sched.sv
// Two-road junction scheduler: NS main road, EW side road and a pedestrian phase,
// with emergency pre-emption towards NS green.
module tlc_junction_sched
    import tlc_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int T_ALLRED = 2,
    parameter int T_GRN_NS = 20,
    parameter int T_GRN_EW = 10,
    parameter int T_YEL    = 3,
    parameter int T_WALK   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_car,
    input  logic       ped_req,
    input  logic       emg,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk,
    output logic       ped_wait,
    output logic       emg_active
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             ew_pend_q;
    logic             ew_pend_d;
    logic             ped_pend_q;
    logic             ped_pend_d;
    logic [CNT_W-1:0] limit;
    logic             tmr_done;
    logic             tmr_clr;
    logic             tmr_sat;

    // Exit compare value is dwell-1 because the count starts at zero on entry.
    always_comb begin
        limit = CNT_W'(T_ALLRED - 1);
        case (state_q)
            S_NS_G:  limit = CNT_W'(T_GRN_NS - 1);
            S_NS_Y:  limit = CNT_W'(T_YEL - 1);
            S_PED:   limit = CNT_W'(T_WALK - 1);
            S_EW_G:  limit = CNT_W'(T_GRN_EW - 1);
            S_EW_Y:  limit = CNT_W'(T_YEL - 1);
            default: limit = CNT_W'(T_ALLRED - 1);
        endcase
    end

    assign tmr_clr = (state_d != state_q);
    assign tmr_sat = (state_q == S_NS_G);

    tlc_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .sat_en_i (tmr_sat),
        .limit_i  (limit),
        .done_o   (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_AR_NS: if (tmr_done) state_d = S_NS_G;
            S_NS_G:  if (tmr_done && !emg && (ew_pend_q || ped_pend_q)) state_d = S_NS_Y;
            S_NS_Y:  if (tmr_done) state_d = S_AR_X;
            S_AR_X: begin
                if (tmr_done) begin
                    if (emg)             state_d = S_NS_G;
                    else if (ped_pend_q) state_d = S_PED;
                    else if (ew_pend_q)  state_d = S_EW_G;
                    else                 state_d = S_NS_G;
                end
            end
            S_PED: begin
                if (emg)           state_d = S_AR_NS;
                else if (tmr_done) state_d = S_AR_X;
            end
            S_EW_G:  if (emg || tmr_done) state_d = S_EW_Y;
            S_EW_Y:  if (tmr_done) state_d = S_AR_NS;
            default: state_d = S_AR_NS;
        endcase
    end

    // A walk aborted by pre-emption leaves the pedestrian request outstanding.
    always_comb begin
        ped_pend_d = ped_pend_q || (ped_req && (state_q != S_PED));
        if (state_q != S_PED && state_d == S_PED) begin
            ped_pend_d = 1'b0;
        end else if (state_q == S_PED && state_d == S_AR_NS) begin
            ped_pend_d = 1'b1;
        end
    end

    always_comb begin
        ew_pend_d = ew_pend_q || (ew_car && (state_q != S_EW_G) && (state_q != S_EW_Y));
        if (state_q != S_EW_G && state_d == S_EW_G) begin
            ew_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_AR_NS;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state_q)
            S_NS_G:  ns_light = GRN;
            S_NS_Y:  ns_light = YEL;
            S_EW_G:  ew_light = GRN;
            S_EW_Y:  ew_light = YEL;
            default: begin
                ns_light = RED;
                ew_light = RED;
            end
        endcase
    end

    assign ped_walk   = (state_q == S_PED);
    assign ped_wait   = ped_pend_q;
    assign emg_active = emg && (state_q == S_NS_G);

endmodule

// File: tb/tb_tlc_junction_sched.sv
// Bench for tlc_junction_sched: directed scenarios with fixed expectations plus a
// randomized run, all compared each cycle against a phase/age reference model.
module tb_tlc_junction_sched;

    localparam int T_ALLRED = 2;
    localparam int T_GRN_NS = 20;
    localparam int T_GRN_EW = 10;
    localparam int T_YEL    = 3;
    localparam int T_WALK   = 8;

    localparam logic [6:0] M_NS   = 7'b1100000;
    localparam logic [6:0] M_EW   = 7'b0011000;
    localparam logic [6:0] M_WALK = 7'b0000100;
    localparam logic [6:0] M_WAIT = 7'b0000010;
    localparam logic [6:0] M_EMGA = 7'b0000001;

    typedef enum int {P_RED_TO_NS, P_NS_GO, P_NS_AMBER, P_RED_X, P_WALK, P_EW_GO, P_EW_AMBER} phase_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ew_car;
    logic       ped_req;
    logic       emg;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;
    logic       ped_wait;
    logic       emg_active;

    int total = 0;
    int bad   = 0;

    phase_t m_phase = P_RED_TO_NS;
    int     m_age   = 0;
    bit     m_ew    = 1'b0;
    bit     m_ped   = 1'b0;

    logic [6:0] trace [0:199];

    always #5 clk = ~clk;

    tlc_junction_sched dut (
        .clk        (clk),
        .rst        (rst),
        .ew_car     (ew_car),
        .ped_req    (ped_req),
        .emg        (emg),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ped_walk   (ped_walk),
        .ped_wait   (ped_wait),
        .emg_active (emg_active)
    );

    function automatic logic [6:0] model_out();
        logic [1:0] ns;
        logic [1:0] ew;
        ns = (m_phase == P_NS_GO) ? 2'b10 : (m_phase == P_NS_AMBER) ? 2'b01 : 2'b00;
        ew = (m_phase == P_EW_GO) ? 2'b10 : (m_phase == P_EW_AMBER) ? 2'b01 : 2'b00;
        return {ns, ew, m_phase == P_WALK, m_ped, emg && (m_phase == P_NS_GO)};
    endfunction

    // Advances the reference by one clock edge using the inputs presented before it.
    task automatic model_step();
        phase_t nxt;
        bit     ped_n;
        bit     ew_n;
        if (rst) begin
            m_phase = P_RED_TO_NS;
            m_age   = 0;
            m_ew    = 1'b0;
            m_ped   = 1'b0;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            P_RED_TO_NS: if (m_age + 1 >= T_ALLRED) nxt = P_NS_GO;
            P_NS_GO:     if (m_age + 1 >= T_GRN_NS && !emg && (m_ew || m_ped)) nxt = P_NS_AMBER;
            P_NS_AMBER:  if (m_age + 1 >= T_YEL) nxt = P_RED_X;
            P_RED_X: begin
                if (m_age + 1 >= T_ALLRED) begin
                    if (emg)        nxt = P_NS_GO;
                    else if (m_ped) nxt = P_WALK;
                    else if (m_ew)  nxt = P_EW_GO;
                    else            nxt = P_NS_GO;
                end
            end
            P_WALK: begin
                if (emg) nxt = P_RED_TO_NS;
                else if (m_age + 1 >= T_WALK) nxt = P_RED_X;
            end
            P_EW_GO:     if (emg || m_age + 1 >= T_GRN_EW) nxt = P_EW_AMBER;
            default:     if (m_age + 1 >= T_YEL) nxt = P_RED_TO_NS;
        endcase
        ped_n = m_ped || (ped_req && m_phase != P_WALK);
        if (nxt == P_WALK && m_phase != P_WALK) ped_n = 1'b0;
        if (m_phase == P_WALK && nxt == P_RED_TO_NS) ped_n = 1'b1;
        ew_n = m_ew || (ew_car && m_phase != P_EW_GO && m_phase != P_EW_AMBER);
        if (nxt == P_EW_GO && m_phase != P_EW_GO) ew_n = 1'b0;
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
        m_ped   = ped_n;
        m_ew    = ew_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [6:0] dut_out();
        return {ns_light, ew_light, ped_walk, ped_wait, emg_active};
    endfunction

    task automatic check_cycle(input string tag, input int c);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = dut_out();
        exp = model_out();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d outputs got=%b want=%b", tag, c, obs, exp);
        end
        total++;
        assert (ns_light != 2'b11 && ew_light != 2'b11 && (ns_light == 2'b00 || ew_light == 2'b00)) else begin
            bad++;
            $error("FAIL %s_safety cyc=%0d got ns=%b ew=%b want one head RED and no code 11", tag, c, ns_light, ew_light);
        end
    endtask

    task automatic spot(input string tag, input int c, input logic [6:0] mask, input logic [6:0] exp);
        total++;
        assert ((trace[c] & mask) === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b want=%b (mask %b)", tag, c, trace[c] & mask, exp, mask);
        end
    endtask

    // Cycle 0 is the first cycle after rst falls; -1 disables an event.
    task automatic scenario(input string tag, input int n, input int ew_at, input int ew2_at,
                            input int ped_at, input int emg_from, input int emg_to, input int rst_at);
        rst = 1'b1; ew_car = 1'b0; ped_req = 1'b0; emg = 1'b0;
        tick();
        tick();
        check_cycle({tag, "_reset"}, -1);
        rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            ew_car  = (c == ew_at) || (c == ew2_at);
            ped_req = (c == ped_at);
            emg     = (c >= emg_from) && (c <= emg_to);
            rst     = (c == rst_at);
            #1;
            check_cycle(tag, c);
            trace[c] = dut_out();
            tick();
        end
        rst = 1'b0; ew_car = 1'b0; ped_req = 1'b0; emg = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ew_car = 1'b0; ped_req = 1'b0; emg = 1'b0;

        scenario("idle", 130, -1, -1, -1, -1, -1, -1);
        spot("idle_ns_c0", 0, M_NS, 7'b0000000);
        spot("idle_ns_c1", 1, M_NS, 7'b0000000);
        spot("idle_ns_c2", 2, M_NS, 7'b1000000);
        spot("idle_ns_c125", 125, M_NS | M_EW, 7'b1000000);

        scenario("ew", 60, 5, -1, -1, -1, -1, -1);
        spot("ew_nsg_c21", 21, M_NS, 7'b1000000);
        spot("ew_nsy_c22", 22, M_NS, 7'b0100000);
        spot("ew_nsy_c24", 24, M_NS, 7'b0100000);
        spot("ew_ar_c25", 25, M_NS | M_EW, 7'b0000000);
        spot("ew_ewg_c27", 27, M_EW, 7'b0010000);
        spot("ew_ewg_c36", 36, M_EW, 7'b0010000);
        spot("ew_ewy_c37", 37, M_EW, 7'b0001000);
        spot("ew_ewy_c39", 39, M_EW, 7'b0001000);
        spot("ew_ar_c40", 40, M_NS | M_EW, 7'b0000000);
        spot("ew_nsg_c42", 42, M_NS, 7'b1000000);

        scenario("ped", 50, -1, -1, 5, -1, -1, -1);
        spot("ped_wait_c5", 5, M_WAIT, 7'b0000000);
        spot("ped_wait_c6", 6, M_WAIT, 7'b0000010);
        spot("ped_wait_c26", 26, M_WAIT, 7'b0000010);
        spot("ped_walk_c27", 27, M_WALK | M_WAIT, 7'b0000100);
        spot("ped_walk_c34", 34, M_WALK, 7'b0000100);
        spot("ped_ar_c35", 35, M_WALK | M_NS, 7'b0000000);
        spot("ped_nsg_c37", 37, M_NS, 7'b1000000);

        scenario("both", 55, 5, -1, 5, -1, -1, -1);
        spot("both_walk_c27", 27, M_WALK, 7'b0000100);
        spot("both_walk_c34", 34, M_WALK, 7'b0000100);
        spot("both_ewg_c37", 37, M_EW, 7'b0010000);
        spot("both_ewg_c46", 46, M_EW, 7'b0010000);
        spot("both_ewy_c47", 47, M_EW, 7'b0001000);
        spot("both_ewy_c49", 49, M_EW, 7'b0001000);

        scenario("emg", 70, 5, 40, -1, 30, 60, -1);
        spot("emg_ewg_c30", 30, M_EW, 7'b0010000);
        spot("emg_ewy_c31", 31, M_EW, 7'b0001000);
        spot("emg_ewy_c33", 33, M_EW, 7'b0001000);
        spot("emg_ar_c34", 34, M_NS | M_EW, 7'b0000000);
        spot("emg_act_c35", 35, M_EMGA, 7'b0000000);
        spot("emg_act_c36", 36, M_NS | M_EMGA, 7'b1000001);
        spot("emg_act_c60", 60, M_EMGA, 7'b0000001);
        spot("emg_act_c61", 61, M_NS | M_EMGA, 7'b1000000);
        spot("emg_nsy_c62", 62, M_NS, 7'b0100000);

        scenario("rstwalk", 45, -1, -1, 5, -1, -1, 30);
        spot("rstwalk_walk_c30", 30, M_WALK, 7'b0000100);
        spot("rstwalk_c31", 31, M_NS | M_EW | M_WALK | M_WAIT, 7'b0000000);
        spot("rstwalk_c32", 32, M_NS, 7'b0000000);
        spot("rstwalk_nsg_c33", 33, M_NS, 7'b1000000);

        // Randomized run: sparse requests, bursty emergency, occasional reset.
        rst = 1'b1; ew_car = 1'b0; ped_req = 1'b0; emg = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            ew_car  = ($urandom_range(0, 9) == 0);
            ped_req = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 39) == 0) emg = ~emg;
            rst     = ($urandom_range(0, 599) == 0);
            #1;
            check_cycle("rand", c);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlc_junction_sched.md
Name: tlc_junction_sched

Overview:
- Scheduler for a two-road junction: main road NS, side road EW, plus a pedestrian crossing.
- Sequences the NS and EW signal heads through safe green/yellow/all-red phases.
- Serves EW car-sensor demand and pedestrian requests, and supports an emergency pre-emption that forces the NS route green.
- Drives the lamp drivers directly, using the team light encoding.

Parameters:
- CNT_W, 8: dwell timer width; must hold the largest T_* value.
- T_ALLRED, 2: all-red clearance, in cycles.
- T_GRN_NS, 20: minimum NS green, in cycles.
- T_GRN_EW, 10: fixed EW green, in cycles.
- T_YEL, 3: yellow, in cycles (both roads).
- T_WALK, 8: pedestrian walk, in cycles.
- Legality: all T_* values are at least 1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- ew_car, in, 1: EW vehicle sensor (level).
- ped_req, in, 1: pedestrian button (level or pulse).
- emg, in, 1: emergency pre-empt (level).
- ns_light, out, 2: NS head; RED=00, YEL=01, GRN=10.
- ew_light, out, 2: EW head; same encoding.
- ped_walk, out, 1: walk lamp.
- ped_wait, out, 1: pedestrian request pending.
- emg_active, out, 1: emg high and state is S_NS_G.

Behaviour:
- Reset and clocking: reset is synchronous active-high on rst, clock clk.
- On reset: state=S_AR_NS, timer=0, ew_pend=0, ped_pend=0. Outputs: ns_light=RED, ew_light=RED, ped_walk=0, ped_wait=0, emg_active=0.
- Reset mid-operation: same values on the next edge; the walk phase aborts and pending requests are dropped.
- Outputs are decoded from the registered state (no input-to-output path). Code 11 is never driven. Both heads are never non-RED together.
- Timer: cleared on every state change, otherwise +1. A dwell of T cycles exits on the edge where timer==T-1. In S_NS_G the timer saturates at T_GRN_NS-1.
- S_AR_NS: both RED; T_ALLRED -> S_NS_G.
- S_NS_G: NS=GRN. When timer>=T_GRN_NS-1, emg=0 and (ew_pend|ped_pend) -> S_NS_Y; otherwise hold.
- S_NS_Y: NS=YEL; T_YEL -> S_AR_X. The dwell is never shortened.
- S_AR_X: both RED; after T_ALLRED, exit in priority order:
  - emg -> S_NS_G;
  - else ped_pend -> S_PED;
  - else ew_pend -> S_EW_G;
  - else -> S_NS_G.
- S_PED: both RED, ped_walk=1; T_WALK -> S_AR_X. If emg: -> S_AR_NS next edge and ped_pend is set again.
- S_EW_G: EW=GRN; T_GRN_EW -> S_EW_Y. If emg: -> S_EW_Y next edge.
- S_EW_Y: EW=YEL; T_YEL -> S_AR_NS.
- ped_pend:
  - set when ped_req=1 in any state except S_PED;
  - cleared on the edge entering S_PED;
  - ped_req on that same edge is ignored;
  - ped_wait = ped_pend.
- ew_pend:
  - set when ew_car=1 in any state except S_EW_G/S_EW_Y;
  - cleared on the edge entering S_EW_G;
  - ew_car on that same edge is ignored.
- Pedestrian served before EW when both are pending.
- emg during yellow or all-red phases does not shorten them. Requests keep latching while emg is high.
- State encoding: 3 bits, 7 states; unused codes -> S_AR_NS.

Decomposition:
- Package tlc_pkg: light codes RED/YEL/GRN and the state enumeration (S_AR_NS, S_NS_G, S_NS_Y, S_AR_X, S_PED, S_EW_G, S_EW_Y).
- Sub-module tlc_dwell_timer: CNT_W up-counter with clear, saturate-enable and done compare against a runtime limit.
- FSM, request latches and output decode stay in the top module.

Test Plan:
- Default parameters. Cycle 0 is the first cycle after rst falls.
- No requests: NS RED cycles 0-1, GRN from cycle 2 held ≥100 cycles; ew_light RED throughout.
- ew_car pulse at cycle 5 -> NS_G 2-21, NS_Y 22-24, AR 25-26, EW_G 27-36, EW_Y 37-39, AR 40-41, NS_G from 42; ped_walk never high.
- ped_req pulse at cycle 5 -> ped_wait high 6-26, ped_walk 27-34, AR 35-36, NS_G from 37.
- ped_req and ew_car both at cycle 5 -> walk 27-34, AR 35-36, EW_G 37-46, EW_Y 47-49.
- ew_car at cycle 5, emg high cycles 30-60 -> EW_Y 31-33, AR 34-35, NS_G from 36, emg_active 36-60. ew_car at 40 is latched; NS_Y starts at 62 (emg=0 sampled at cycle 61).
- rst during walk (cycle 30 of the ped_req scenario) -> cycle 31: both RED, ped_walk=0, ped_wait=0. Then the normal reset sequence resumes.
